// File: rtl/sum_8bit_rr_sched_pkg.sv
// Shared constants and types for the round-robin shared adder.
package sum_8bit_rr_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 8;
    localparam int OPS_W    = 16;

    typedef logic [$clog2(NREQ_DEF)-1:0] req_idx_t;

endpackage

// File: rtl/sum8_core.sv
// Unsigned W-bit adder with carry out; purely combinational, zero latency,
// no flow control of its own.
module sum8_core #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/sum_8bit_rr_sched.sv
// Round-robin arbiter sharing one adder among NREQ requesters; 1-cycle latency.
// Grants only while the result register is empty or draining (rsp_ready).
module sum_8bit_rr_sched
    import sum_8bit_rr_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_sum,
    output logic                    rsp_cout,
    output logic [OPS_W-1:0]        ops_done
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]    last_grant_q, last_grant_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [IW-1:0]    rsp_id_q, rsp_id_d;
    logic [OPS_W-1:0] ops_done_q, ops_done_d;

    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    cand;
    logic             found;
    logic             accept_en;
    logic             req_hs;
    logic             rsp_hs;
    logic [W-1:0]     sel_a, sel_b;
    logic [W-1:0]     core_sum;
    logic             core_cout;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_grant_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept_en = !rsp_valid_q || rsp_ready;
    assign req_ready = accept_en ? grant : '0;
    assign req_hs    = |(req_valid & req_ready);
    assign rsp_hs    = rsp_valid_q && rsp_ready;

    assign sel_a = req_a[grant_idx*W +: W];
    assign sel_b = req_b[grant_idx*W +: W];

    sum8_core #(.W(W)) u_core (
        .a    (sel_a),
        .b    (sel_b),
        .sum  (core_sum),
        .cout (core_cout)
    );

    always_comb begin
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_id_d     = rsp_id_q;
        ops_done_d   = ops_done_q;
        if (req_hs) begin
            rsp_valid_d  = 1'b1;
            rsp_sum_d    = core_sum;
            rsp_cout_d   = core_cout;
            rsp_id_d     = grant_idx;
            last_grant_d = grant_idx;
        end else if (rsp_hs) begin
            rsp_valid_d = 1'b0;
        end
        if (rsp_hs) begin
            ops_done_d = ops_done_q + OPS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IW'(NREQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_id_q     <= '0;
            ops_done_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_id_q     <= rsp_id_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_sum_8bit_rr_sched.sv
// Directed plus randomized bench for sum_8bit_rr_sched against a behavioural model.
module tb_sum_8bit_rr_sched;
    import sum_8bit_rr_sched_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    req_idx_t    rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_cout;
    logic [15:0] ops_done;

    sum_8bit_rr_sched #(.NREQ(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] a_arr [4];
    logic [7:0] b_arr [4];
    int         m_last;
    bit         m_valid;
    int         m_sum;
    int         m_cout;
    int         m_id;
    int         m_ops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = 3;
        m_valid = 1'b0;
        m_sum   = 0;
        m_cout  = 0;
        m_id    = 0;
        m_ops   = 0;
    endtask

    task automatic pack_ops();
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = a_arr[i];
            req_b[i*8 +: 8] = b_arr[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = 8'($urandom);
            b_arr[i] = 8'($urandom);
        end
        pack_ops();
    endtask

    // One clock cycle starting at a negedge: drive, check, advance model and DUT.
    task automatic cycle(input logic [3:0] v, input logic rdy, output int g);
        int       total;
        bit       rsp_hs;
        logic [3:0] exp_rdy;
        req_valid = v;
        rsp_ready = rdy;
        #1;
        g = -1;
        if (!m_valid || rdy) begin
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && v[(m_last + k) % 4]) g = (m_last + k) % 4;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_sum",   32'(rsp_sum),   32'(m_sum));
        chk("rsp_cout",  32'(rsp_cout),  32'(m_cout));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        chk("ops_done",  32'(ops_done),  32'(m_ops));
        rsp_hs = m_valid && rdy;
        if (g >= 0) begin
            total   = int'(a_arr[g]) + int'(b_arr[g]);
            m_sum   = total % 256;
            m_cout  = total / 256;
            m_id    = g;
            m_last  = g;
            m_valid = 1'b1;
        end else if (rsp_hs) begin
            m_valid = 1'b0;
        end
        if (rsp_hs) m_ops = (m_ops + 1) % 65536;
        @(negedge clk);
    endtask

    initial begin
        int g;
        int grants [$];
        int exp_order [8];
        logic [7:0] held_sum;
        int n;

        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        pack_ops();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_ops",   32'(ops_done),  32'd0);
        rst_n = 1'b1;

        // Single request on requester 0
        a_arr[0] = 8'h7F; b_arr[0] = 8'h01; pack_ops();
        cycle(4'b0001, 1'b1, g);
        chk("single_grant", 32'(g), 32'd0);
        cycle(4'b0000, 1'b0, g);
        chk("single_sum",  32'(rsp_sum),  32'h80);
        chk("single_cout", 32'(rsp_cout), 32'd0);
        chk("single_id",   32'(rsp_id),   32'd0);
        cycle(4'b0000, 1'b1, g);

        // Overflow on requester 2
        a_arr[2] = 8'hFF; b_arr[2] = 8'h02; pack_ops();
        cycle(4'b0100, 1'b1, g);
        cycle(4'b0000, 1'b0, g);
        chk("ovf_sum",  32'(rsp_sum),  32'h01);
        chk("ovf_cout", 32'(rsp_cout), 32'd1);
        chk("ovf_id",   32'(rsp_id),   32'd2);
        cycle(4'b0000, 1'b1, g);

        // Fairness from a fresh reset
        rst_n = 1'b0; model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rand_ops();
            cycle(4'b1111, 1'b1, g);
            grants.push_back(g);
        end
        for (int c = 0; c < 8; c++) chk("fair_order", 32'(grants[c]), 32'(exp_order[c]));
        cycle(4'b0000, 1'b1, g);
        chk("fair_ops", 32'(ops_done), 32'd8);

        // Backpressure with requests pending
        rand_ops();
        cycle(4'b1111, 1'b1, g);
        chk("bp_first", 32'(g), 32'd0);
        held_sum = rsp_sum;
        for (int c = 0; c < 3; c++) begin
            rand_ops();
            cycle(4'b1111, 1'b0, g);
            chk("bp_ready_zero", 32'(req_ready), 32'd0);
            chk("bp_sum_stable", 32'(rsp_sum),   32'(held_sum));
        end
        cycle(4'b1111, 1'b1, g);
        chk("bp_release_grant", 32'(g), 32'd1);

        // Randomized traffic
        for (int c = 0; c < 300; c++) begin
            rand_ops();
            cycle(4'($urandom), 1'($urandom), g);
        end

        // Reset while a result is held
        cycle(4'b0001, 1'b0, g);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_sum",   32'(rsp_sum),   32'd0);
        chk("rst_mid_cout",  32'(rsp_cout),  32'd0);
        chk("rst_mid_id",    32'(rsp_id),    32'd0);
        chk("rst_mid_ops",   32'(ops_done),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rand_ops();
        cycle(4'b1111, 1'b1, g);
        chk("rst_first_win", 32'(g), 32'd0);

        // Counter wrap through sustained 1-per-cycle traffic
        n = 0;
        while (m_ops != 16'hFFFF && n < 70000) begin
            cycle(4'b0001, 1'b1, g);
            n++;
        end
        chk("wrap_preload", 32'(ops_done), 32'hFFFF);
        cycle(4'b0001, 1'b1, g);
        chk("wrap_zero", 32'(ops_done), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
